// File: rtl/pool_window_feeder_if.sv
// Handshake bundle between a raster pixel source, the 2x2 window feeder and the pooling tree.
// The feeder binds to the slave modport; whatever sources pixels and consumes windows uses master.
interface pool_window_feeder_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] win0;
    logic [DATA_W-1:0] win1;
    logic [DATA_W-1:0] win2;
    logic [DATA_W-1:0] win3;
    logic              win_valid;
    logic              win_ready;
    logic              win_last;
    logic              frame_done;

    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, win0, win1, win2, win3, win_valid, win_last, frame_done
    );

    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, win0, win1, win2, win3, win_valid, win_last, frame_done
    );
endinterface

// File: rtl/pool_window_feeder.sv
// Buffers each even row of a raster feature map and emits every non-overlapping 2x2 window
// as four parallel words; a stalled window holds the pixel stream off through pix_ready.
module pool_window_feeder #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    pool_window_feeder_if.slave  bus
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_PAIR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [DATA_W-1:0] r_linebuf [IMG_W];
    logic [DATA_W-1:0] r_left;
    logic [DATA_W-1:0] r_win0;
    logic [DATA_W-1:0] r_win1;
    logic [DATA_W-1:0] r_win2;
    logic [DATA_W-1:0] r_win3;
    logic              r_win_valid;
    logic              r_win_last;
    logic              r_frame_done;

    logic              w_pix_ready;
    logic              w_accept;
    logic              w_handoff;
    logic              w_col_wrap;
    logic              w_row_wrap;
    logic [CW-1:0]     w_col_prev;
    logic              w_lb_we;
    logic              w_left_we;
    logic              w_win_load;

    // A pixel may only enter when the output register is free or being emptied this cycle.
    assign w_pix_ready = ~r_win_valid | bus.win_ready;
    assign w_accept    = bus.pix_valid & w_pix_ready & ~clr;
    assign w_handoff   = r_win_valid & bus.win_ready;
    assign w_col_wrap  = (r_col == COL_LAST);
    assign w_row_wrap  = (r_row == ROW_LAST);
    assign w_col_prev  = r_col - CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Row parity: even rows fill the line buffer, odd rows pair with it to form windows.
    always_comb begin
        w_state_nxt = r_state;
        w_lb_we     = 1'b0;
        w_left_we   = 1'b0;
        w_win_load  = 1'b0;
        if (clr) begin
            w_state_nxt = S_FILL;
        end else if (w_accept) begin
            unique case (r_state)
                S_FILL: begin
                    w_lb_we = 1'b1;
                    if (w_col_wrap) begin
                        w_state_nxt = S_PAIR;
                    end
                end
                S_PAIR: begin
                    if (r_col[0]) begin
                        w_win_load = 1'b1;
                    end else begin
                        w_left_we = 1'b1;
                    end
                    if (w_col_wrap) begin
                        w_state_nxt = S_FILL;
                    end
                end
                default: begin
                    w_state_nxt = S_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Contents are only meaningful once a FILL row has written them, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_lb_we) begin
            r_linebuf[r_col] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left <= '0;
        end else if (clr) begin
            r_left <= '0;
        end else if (w_left_we) begin
            r_left <= bus.pix_in;
        end
    end

    // A reload never collides with a stall: loading needs an accepted pixel, which needs ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win0       <= '0;
            r_win1       <= '0;
            r_win2       <= '0;
            r_win3       <= '0;
            r_win_valid  <= 1'b0;
            r_win_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_handoff & r_win_last & ~clr;
            if (clr) begin
                r_win_valid <= 1'b0;
                r_win_last  <= 1'b0;
            end else if (w_win_load) begin
                r_win0      <= r_linebuf[w_col_prev];
                r_win1      <= r_linebuf[r_col];
                r_win2      <= r_left;
                r_win3      <= bus.pix_in;
                r_win_valid <= 1'b1;
                r_win_last  <= w_row_wrap & w_col_wrap;
            end else if (w_handoff) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign bus.pix_ready  = w_pix_ready;
    assign bus.win0       = r_win0;
    assign bus.win1       = r_win1;
    assign bus.win2       = r_win2;
    assign bus.win3       = r_win3;
    assign bus.win_valid  = r_win_valid;
    assign bus.win_last   = r_win_last;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder: a 4x4 instance for directed scenarios and an 8x8 instance
// for randomized bubbles, both checked every cycle against a frame-array reference model.
module tb_pool_window_feeder;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int AH = 4;
    localparam int BW = 8;
    localparam int BH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clrA;
    logic clrB;

    pool_window_feeder_if #(.DATA_W(DW)) ifA ();
    pool_window_feeder_if #(.DATA_W(DW)) ifB ();

    pool_window_feeder #(.DATA_W(DW), .IMG_W(AW), .IMG_H(AH)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clrA),
        .bus   (ifA.slave)
    );

    pool_window_feeder #(.DATA_W(DW), .IMG_W(BW), .IMG_H(BH)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clrB),
        .bus   (ifB.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: pixels are stored by their index within the frame; a window is due
    // whenever the accepted pixel sits on an odd row and an odd column.
    int          nA, nB;
    bit          vA, vB, lastA, lastB, fdA, fdB, handA, handB;
    logic [31:0] wA [4];
    logic [31:0] wB [4];
    logic [31:0] frA [AW*AH];
    logic [31:0] frB [BW*BH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nA = 0; vA = 0; lastA = 0; fdA = 0;
            for (int k = 0; k < 4; k++) wA[k] = '0;
        end else begin
            handA = vA && ifA.win_ready;
            fdA   = handA && lastA && !clrA;
            if (clrA) begin
                nA = 0; vA = 0; lastA = 0;
            end else begin
                if (handA) vA = 0;
                if (ifA.pix_valid && (!vA || handA || ifA.win_ready)) begin
                    frA[nA] = ifA.pix_in;
                    if (((nA / AW) % 2 == 1) && ((nA % AW) % 2 == 1)) begin
                        wA[0] = frA[nA-AW-1]; wA[1] = frA[nA-AW];
                        wA[2] = frA[nA-1];    wA[3] = ifA.pix_in;
                        vA = 1; lastA = (nA == AW*AH-1);
                    end
                    nA = (nA + 1) % (AW*AH);
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nB = 0; vB = 0; lastB = 0; fdB = 0;
            for (int k = 0; k < 4; k++) wB[k] = '0;
        end else begin
            handB = vB && ifB.win_ready;
            fdB   = handB && lastB && !clrB;
            if (clrB) begin
                nB = 0; vB = 0; lastB = 0;
            end else begin
                if (handB) vB = 0;
                if (ifB.pix_valid && (!vB || handB || ifB.win_ready)) begin
                    frB[nB] = ifB.pix_in;
                    if (((nB / BW) % 2 == 1) && ((nB % BW) % 2 == 1)) begin
                        wB[0] = frB[nB-BW-1]; wB[1] = frB[nB-BW];
                        wB[2] = frB[nB-1];    wB[3] = ifB.pix_in;
                        vB = 1; lastB = (nB == BW*BH-1);
                    end
                    nB = (nB + 1) % (BW*BH);
                end
            end
        end
    end

    logic [128:0] capA [$];
    logic [128:0] capB [$];
    int           fdcntA = 0;
    int           fdcntB = 0;

    // Per-cycle comparison against the model, plus capture of every handed-off window.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("A.pix_ready",  ifA.pix_ready,  !vA || ifA.win_ready);
            chk("A.win_valid",  ifA.win_valid,  vA);
            chk("A.frame_done", ifA.frame_done, fdA);
            if (vA) begin
                chk("A.window", {ifA.win0, ifA.win1, ifA.win2, ifA.win3}, {wA[0], wA[1], wA[2], wA[3]});
                chk("A.win_last", ifA.win_last, lastA);
            end
            chk("B.pix_ready",  ifB.pix_ready,  !vB || ifB.win_ready);
            chk("B.win_valid",  ifB.win_valid,  vB);
            chk("B.frame_done", ifB.frame_done, fdB);
            if (vB) begin
                chk("B.window", {ifB.win0, ifB.win1, ifB.win2, ifB.win3}, {wB[0], wB[1], wB[2], wB[3]});
                chk("B.win_last", ifB.win_last, lastB);
            end
            if (ifA.win_valid && ifA.win_ready)
                capA.push_back({ifA.win_last, ifA.win0, ifA.win1, ifA.win2, ifA.win3});
            if (ifB.win_valid && ifB.win_ready)
                capB.push_back({ifB.win_last, ifB.win0, ifB.win1, ifB.win2, ifB.win3});
            if (ifA.frame_done) fdcntA++;
            if (ifB.frame_done) fdcntB++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Streams base+0 .. base+n-1 into instance A; optionally stalls the first window.
    task automatic streamA(input int n, input int base, input int stall_len);
        int i = 0;
        int cyc = 0;
        int scnt = 0;
        bit armed = 0;
        while (i < n && cyc < 400) begin
            ifA.pix_valid = 1'b1;
            ifA.pix_in    = 32'(base + i);
            if (stall_len > 0 && !armed && ifA.win_valid) begin
                armed = 1;
                scnt  = stall_len;
            end
            if (scnt > 0) begin
                ifA.win_ready = 1'b0;
                scnt--;
            end else begin
                ifA.win_ready = 1'b1;
            end
            @(negedge clk);
            if (ifA.pix_ready && !clrA) i++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("A.stream_accepted", 129'(i), 129'(n));
        ifA.pix_valid = 1'b0;
        ifA.win_ready = 1'b1;
    endtask

    task automatic check_basic(input string tag);
        logic [128:0] exp_tab [4];
        exp_tab[0] = {1'b0, 32'd0,  32'd1,  32'd4,  32'd5};
        exp_tab[1] = {1'b0, 32'd2,  32'd3,  32'd6,  32'd7};
        exp_tab[2] = {1'b0, 32'd8,  32'd9,  32'd12, 32'd13};
        exp_tab[3] = {1'b1, 32'd10, 32'd11, 32'd14, 32'd15};
        chk({tag, ".win_count"}, 129'(capA.size()), 129'd4);
        for (int k = 0; k < 4 && k < capA.size(); k++)
            chk($sformatf("%s.win%0d", tag, k), capA[k], exp_tab[k]);
        chk({tag, ".frame_done_count"}, 129'(fdcntA), 129'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clrA = 1'b0; clrB = 1'b0;
        ifA.pix_valid = 1'b0; ifA.pix_in = '0; ifA.win_ready = 1'b1;
        ifB.pix_valid = 1'b0; ifB.pix_in = '0; ifB.win_ready = 1'b1;
        #12;
        chk("rst.A.win_valid",  ifA.win_valid,  1'b0);
        chk("rst.A.pix_ready",  ifA.pix_ready,  1'b1);
        chk("rst.A.frame_done", ifA.frame_done, 1'b0);
        chk("rst.A.win_last",   ifA.win_last,   1'b0);
        chk("rst.A.window", {ifA.win0, ifA.win1, ifA.win2, ifA.win3}, 128'd0);
        chk("rst.B.window", {ifB.win0, ifB.win1, ifB.win2, ifB.win3}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Basic back-to-back frame.
        capA.delete(); fdcntA = 0;
        streamA(16, 0, 0);
        idle(4);
        check_basic("basic");

        // First window stalled for three cycles.
        capA.delete(); fdcntA = 0;
        streamA(16, 0, 3);
        idle(4);
        check_basic("stall");

        // Partial frame, then clr with a pixel offered in the same cycle.
        streamA(6, 100, 0);
        chk("clr.pre_valid", ifA.win_valid, 1'b1);
        clrA = 1'b1; ifA.pix_valid = 1'b1; ifA.pix_in = 32'hDEAD;
        @(posedge clk); #1;
        clrA = 1'b0; ifA.pix_valid = 1'b0;
        chk("clr.valid_cleared", ifA.win_valid, 1'b0);
        capA.delete(); fdcntA = 0;
        streamA(16, 0, 0);
        idle(4);
        check_basic("clr");

        // Asynchronous reset while a window is stalled.
        streamA(6, 200, 0);
        ifA.win_ready = 1'b0;
        @(posedge clk); #1;
        chk("arst.pre_valid", ifA.win_valid, 1'b1);
        chk("arst.pre_ready", ifA.pix_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.win_valid", ifA.win_valid, 1'b0);
        chk("arst.pix_ready", ifA.pix_ready, 1'b1);
        chk("arst.win_last",  ifA.win_last,  1'b0);
        chk("arst.window", {ifA.win0, ifA.win1, ifA.win2, ifA.win3}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifA.win_ready = 1'b1;
        capA.delete(); fdcntA = 0;
        streamA(16, 0, 0);
        idle(4);
        check_basic("arst");

        // Two 8x8 frames with random bubbles on both sides.
        begin
            int i = 0;
            int cyc = 0;
            capB.delete(); fdcntB = 0;
            while (i < 2*BW*BH && cyc < 5000) begin
                ifB.pix_valid = 1'($urandom_range(0, 1));
                ifB.win_ready = 1'($urandom_range(0, 1));
                ifB.pix_in    = 32'(i);
                @(negedge clk);
                if (ifB.pix_valid && ifB.pix_ready) i++;
                @(posedge clk); #1;
                cyc++;
            end
            chk("rand.accepted", 129'(i), 129'(2*BW*BH));
            ifB.pix_valid = 1'b0;
            ifB.win_ready = 1'b1;
            idle(4);
            chk("rand.win_count", 129'(capB.size()), 129'd32);
            chk("rand.frame_done_count", 129'(fdcntB), 129'd2);
            for (int k = 0; k < 32 && k < capB.size(); k++) begin
                int f, wr, wc, tl;
                f  = k / 16;
                wr = (k % 16) / 4;
                wc = k % 4;
                tl = f*64 + 2*wr*BW + 2*wc;
                chk($sformatf("rand.win%0d", k), capB[k],
                    {(k % 16 == 15), 32'(tl), 32'(tl+1), 32'(tl+BW), 32'(tl+BW+1)});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
